// File: rtl/delay_line_ctrl_pkg.sv
// Shared types and constants for the runtime-programmable sample delay line.
package delay_line_ctrl_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int CFG_DRAIN = 2;

  function automatic int addr_width(input int max_delay);
    return $clog2(max_delay + 1);
  endfunction

endpackage

// File: rtl/delay_line_ctrl_sdp_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port, contents never reset.
module sdp_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2048,
  parameter     STYLE = "M20K"
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  (* ramstyle = STYLE *) logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/delay_line_ctrl.sv
// Circular-buffer sample delay with runtime delay reconfiguration and zero-fill after each change.
module delay_line_ctrl
  import delay_line_ctrl_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int MAX_DELAY     = 1024,
  parameter int DEFAULT_DELAY = 16,
  parameter     STYLE         = "M20K"
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  logic [$clog2(MAX_DELAY+1)-1:0]   cfg_delay,
  output logic                             cfg_err,
  input  logic                             s_valid,
  input  logic [WIDTH-1:0]                 s_data,
  output logic                             m_valid,
  output logic [WIDTH-1:0]                 m_data,
  output logic                             busy
);

  localparam int AW = addr_width(MAX_DELAY);
  localparam int DW = $clog2(MAX_DELAY + 1);

  state_t          state, state_nxt;
  logic [DW-1:0]   d_cur;
  logic [DW-1:0]   fill_cnt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_addr;
  logic [1:0]      drain_cnt;
  logic            cfg_acc;
  logic            cfg_legal;
  logic            fill_done;
  logic            vld_p0;
  logic            mask_p0;
  logic [WIDTH-1:0] rd_data_p0;

  assign cfg_acc   = cfg_valid && cfg_ready;
  assign cfg_legal = (cfg_delay != '0) && (cfg_delay <= DW'(MAX_DELAY));
  assign fill_done = s_valid && (state == FILL) && (fill_cnt == d_cur - DW'(1));
  // Depth exceeds MAX_DELAY, so this never aliases the write address.
  assign rd_addr   = wr_ptr - AW'(d_cur);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cfg_acc && cfg_legal) state_nxt = FILL;
    else if (fill_done)       state_nxt = RUN;
  end

  always_comb begin
    busy      = (state == FILL);
    cfg_ready = (drain_cnt == 2'd0);
  end

  // Stage 0: buffer write, registered read, zero mask decided at read issue
  sdp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (2**AW),
    .STYLE (STYLE)
  ) u_ram (
    .clk     (clk),
    .we      (s_valid),
    .wr_addr (wr_ptr),
    .wr_data (s_data),
    .re      (s_valid),
    .rd_addr (rd_addr),
    .rd_data (rd_data_p0)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_cur     <= DW'(DEFAULT_DELAY);
      fill_cnt  <= '0;
      wr_ptr    <= '0;
      drain_cnt <= '0;
      cfg_err   <= 1'b0;
      vld_p0    <= 1'b0;
      mask_p0   <= 1'b1;
      m_valid   <= 1'b0;
    end else begin
      cfg_err <= cfg_acc && !cfg_legal;
      vld_p0  <= s_valid;
      m_valid <= vld_p0;
      if (s_valid) begin
        wr_ptr  <= wr_ptr + AW'(1);
        mask_p0 <= (state == FILL);
        if (state == FILL) fill_cnt <= fill_cnt + DW'(1);
      end
      if (cfg_acc)                drain_cnt <= 2'(CFG_DRAIN);
      else if (drain_cnt != 2'd0) drain_cnt <= drain_cnt - 2'd1;
      // A new delay overrides the sample-path update issued in the same cycle.
      if (cfg_acc && cfg_legal) begin
        d_cur    <= cfg_delay;
        fill_cnt <= '0;
      end
    end
  end

  // Stage 1: zero-mask mux into the output register
  always_ff @(posedge clk) begin
    if (!rst_n)      m_data <= '0;
    else if (vld_p0) m_data <= mask_p0 ? '0 : rd_data_p0;
  end

endmodule
